bin_to_seg8: RTL
================

Name: bin_to_seg8

Overview:
- Upstream feeder for the 8-digit multiplexed 7-segment driver.
- Converts an unsigned binary value to 8 BCD digits using a sequential double-dabble (shift-add-3) engine. Encodes each digit as an active-low segment byte.
- Presents the result on eight registered display outputs (display0..display7) that connect directly to the driver's display inputs.
- Outputs update atomically only at the end of a conversion. They hold stable between conversions.

Parameters:
- IN_WIDTH, 27, width of bin_in. 27 bits covers the 8-digit maximum of 99_999_999.
- LZ_BLANK, 1, 1 = blank leading zeros. Digit 7 (least significant) is never blanked.

Ports:
- clk_out  input  1  block clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- bin_in  input  IN_WIDTH  unsigned value; latched on the accepted start
- dp_in  input  8  decimal-point enables, active-high; dp_in[7] maps to display0 and dp_in[0] maps to display7; latched on the accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse, coincident with the display update
- overflow  output  1  registered flag; set when the last conversion had bin_in > 99_999_999
- display0..display7  output  8 each  active-low segment bytes; display0 is the most significant (leftmost) digit

Behaviour:
- Segment byte format: bit7..bit0 = {a,b,c,d,e,f,g,dp}, active-low.
- Digit codes: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
- Special codes: blank=FF, dash=FD.
- DP handling: if the latched dp bit is 1, bit0 of that digit's byte is cleared. This applies to blanked digits too (FF becomes FE).
- Reset (async, low): state=IDLE, busy=0, done=0, overflow=0, all display outputs=FF, internal shift/BCD registers=0.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE + start=1:
  - Latch bin_in and dp_in.
  - Clear the 32-bit BCD register and bit counter.
  - Go to SHIFT; busy=1 from the next cycle.
- SHIFT, one iteration per clk_out edge:
  - Each BCD nibble >= 5 gets +3.
  - Then shift {bcd,bin} left by 1.
  - After exactly IN_WIDTH iterations, go to LOAD.
- LOAD:
  - Register all eight display outputs.
  - Set overflow, and pulse done=1 for one cycle.
  - Return to IDLE; busy=0 in the same cycle done is high.
- Latency: start accepted at edge E0 → displays, overflow and done change at edge E0+IN_WIDTH+1 (E28 at the default width).
- Start is ignored (not queued) while busy=1, including in the LOAD cycle.
- Overflow: if the latched value > 99_999_999, all eight digits show dash (FD, DP still applied) and overflow=1. Otherwise overflow=0.
- Leading-zero blanking (LZ_BLANK=1):
  - Digits 0..6 that are 0 and have only zeros to their left show FF.
  - Digit 7 always shows its numeral.
  - A zero right of the first nonzero digit shows 03.
  - With LZ_BLANK=0, every digit shows its numeral.
- Displays are never partially updated; intermediate BCD values are never visible.
- Reset mid-conversion: immediate abort to reset values. No done pulse follows.
- bin_in and dp_in changes after acceptance have no effect on the running conversion.

Test Plan:
- Reset asserted → display0..7=FF, busy=0, done=0, overflow=0. After release with start=0 for 50 cycles → all outputs unchanged.
- start with bin_in=12_345_678, dp_in=0 → busy high 28 cycles. Done pulses at E0+28; display0..7 = 9F,25,0D,99,49,41,1F,01.
- bin_in=1_005, dp_in=8'b0000_0100, LZ_BLANK=1 → display0..3=FF, display4=9F, display5=FE+03 merge=02, display6=03, display7=49. Same value with LZ_BLANK=0 → display0..3=03.
- bin_in=0 → display0..6=FF, display7=03. Then bin_in=100_000_000 → all displays FD, overflow=1. Then bin_in=7 → overflow=0, display7=1F.
- Start at E0 (value 42), second start at E5 (value 99) → only one done at E0+28, displays show 42. Busy never drops early.
- Reset pulled low at E0+10 during a conversion with prior displays showing 42 → displays=FF immediately, busy=0, no done pulse. A new start after release converts normally.

Source files
------------

// File: rtl/bin_to_seg8.sv
// Binary to 8-digit active-low 7-segment converter. A sequential double-dabble
// engine produces the BCD digits, and the display bytes are registered in one update at the end.

module bin_to_seg8_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module bin_to_seg8_digit (
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  input  logic       dash_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  always_comb begin
    seg_o = 8'hFF;
    if (dash_i) begin
      seg_o = 8'hFD;
    end else if (!blank_i) begin
      case (nib_i)
        4'd0:    seg_o = 8'h03;
        4'd1:    seg_o = 8'h9F;
        4'd2:    seg_o = 8'h25;
        4'd3:    seg_o = 8'h0D;
        4'd4:    seg_o = 8'h99;
        4'd5:    seg_o = 8'h49;
        4'd6:    seg_o = 8'h41;
        4'd7:    seg_o = 8'h1F;
        4'd8:    seg_o = 8'h01;
        4'd9:    seg_o = 8'h09;
        default: seg_o = 8'hFF;
      endcase
    end
    // The decimal point applies to blanked and dashed digits as well.
    if (dp_i) seg_o[0] = 1'b0;
  end
endmodule

module bin_to_seg8 #(
  parameter int IN_WIDTH = 27,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                clk_out,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic [7:0]          dp_in,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [7:0]          display0,
  output logic [7:0]          display1,
  output logic [7:0]          display2,
  output logic [7:0]          display3,
  output logic [7:0]          display4,
  output logic [7:0]          display5,
  output logic [7:0]          display6,
  output logic [7:0]          display7
);
  localparam int NUM_DIG = 8;
  localparam int CW      = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                         state_q, state_d;
  logic [IN_WIDTH-1:0]            bin_q, bin_d;
  logic [4*NUM_DIG-1:0]           bcd_q, bcd_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [7:0]                     dp_q, dp_d;
  logic                           ovf_pend_q, ovf_pend_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           ovf_q, ovf_d;
  logic [NUM_DIG-1:0][7:0]        disp_q, disp_d;

  logic [4*NUM_DIG-1:0]           bcd_adj;
  logic [NUM_DIG-1:0]             blank_w;
  logic [NUM_DIG-1:0][7:0]        seg_w;
  logic                           ovf_in;

  // The BCD register cannot hold a ninth digit, so range is judged on the raw input.
  assign ovf_in = ({{(64-IN_WIDTH){1'b0}}, bin_in} > 64'd99_999_999);

  // Digit 0 (leftmost) lives in the top nibble of the BCD register.
  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      bin_to_seg8_add3 u_add3 (
        .nib_i (bcd_q[4*g +: 4]),
        .nib_o (bcd_adj[4*g +: 4])
      );
      bin_to_seg8_digit u_seg (
        .nib_i   (bcd_q[4*(NUM_DIG-1-g) +: 4]),
        .blank_i (blank_w[g]),
        .dash_i  (ovf_pend_q),
        .dp_i    (dp_q[NUM_DIG-1-g]),
        .seg_o   (seg_w[g])
      );
    end
  endgenerate

  always_comb begin
    logic run;
    run     = 1'b1;
    blank_w = '0;
    for (int i = 0; i < NUM_DIG - 1; i++) begin
      run        = run && (bcd_q[4*(NUM_DIG-1-i) +: 4] == 4'd0);
      blank_w[i] = LZ_BLANK && run;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dp_d       = dp_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin_in;
          dp_d       = dp_in;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ovf_in;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[4*NUM_DIG-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = LOAD;
      end
      LOAD: begin
        disp_d  = seg_w;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      dp_q       <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= {NUM_DIG{8'hFF}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      dp_q       <= dp_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign display0 = disp_q[0];
  assign display1 = disp_q[1];
  assign display2 = disp_q[2];
  assign display3 = disp_q[3];
  assign display4 = disp_q[4];
  assign display5 = disp_q[5];
  assign display6 = disp_q[6];
  assign display7 = disp_q[7];
endmodule
